// File: rtl/display_scan_if.sv
// Pad-side bundle of the seven-segment scan driver: load path from the
// counter datapath plus the digit-enable / segment pad outputs.
interface display_scan_if #(
    parameter int N_DIGITS = 6
);
    logic                      load;
    logic [4*N_DIGITS-1:0]     digits_in;
    logic                      blank_lz;
    logic [N_DIGITS-1:0]       disp;
    logic [6:0]                segm;
    logic                      frame_done;
    logic                      busy_pending;

    // Producer of digit codes; observes the pads and status.
    modport master (
        output load, digits_in, blank_lz,
        input  disp, segm, frame_done, busy_pending
    );

    // The scan driver itself.
    modport slave (
        input  load, digits_in, blank_lz,
        output disp, segm, frame_done, busy_pending
    );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed common-anode seven-segment driver. Digit codes are
// double-buffered (pending -> active at the frame boundary) so a frame is
// never torn; each digit is lit for SCAN_DIV cycles with a GUARD-cycle
// all-off gap in between. Optional leading-zero blanking.
module display_scan #(
    parameter int N_DIGITS = 6,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 4
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);
    localparam int CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW      = 4 * N_DIGITS;

    localparam logic [N_DIGITS-1:0] DIGIT0   = N_DIGITS'(1);
    localparam logic [6:0]          SEG_OFF  = 7'h7F;
    localparam logic [CW-1:0]       GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0]       SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);

    typedef enum logic {
        S_GUARD,
        S_SHOW
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;     // digit to light on next SHOW entry
    logic                  last_q, last_d;   // digit just lit was the leftmost one
    logic [N_DIGITS-1:0]   disp_q, disp_d;
    logic [6:0]            segm_q, segm_d;
    logic [DW-1:0]         active_q;
    logic [DW-1:0]         pending_q;
    logic                  busy_q;

    logic                  boundary;
    logic                  commit;
    logic [DW-1:0]         view;
    logic [3:0]            code;
    logic                  upper_zero;
    logic                  blank;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // The last GUARD cycle after the leftmost digit closes the frame. When a
    // commit happens on that edge, the digit-0 glyph registered on the same
    // edge must come from the pending value, hence the view mux.
    assign boundary   = (state_q == S_GUARD) && (cnt_q == GUARD_LAST) && last_q;
    assign commit     = boundary && busy_q;
    assign view       = commit ? pending_q : active_q;
    assign code       = view[{idx_q, 2'b00} +: 4];
    assign upper_zero = ((view >> {idx_q, 2'b00}) == '0);
    assign blank      = bus.blank_lz && (idx_q != '0) && upper_zero;

    // Next-state and registered-output values for the scan FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        last_d  = last_q;
        disp_d  = disp_q;
        segm_d  = segm_q;
        unique case (state_q)
            S_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                    disp_d  = ~(DIGIT0 << idx_q);
                    segm_d  = blank ? SEG_OFF : glyph(code);
                    last_d  = (idx_q == IDX_LAST);
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                    disp_d  = '1;
                    segm_d  = SEG_OFF;
                end
            end
            default: begin
                state_d = S_GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pad registers and the pending/active digit buffers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= S_GUARD;
            cnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            disp_q    <= '1;
            segm_q    <= SEG_OFF;
            // NOTE: the digit buffers are reset too, so a reset mid-pending leaves nothing to commit.
            active_q  <= '0;
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            disp_q  <= disp_d;
            segm_q  <= segm_d;
            if (commit) begin
                active_q <= pending_q;
            end
            // A load on the boundary edge lands in pending and stays pending.
            if (bus.load) begin
                pending_q <= bus.digits_in;
                busy_q    <= 1'b1;
            end else if (commit) begin
                busy_q    <= 1'b0;
            end
        end
    end

    assign bus.disp         = disp_q;
    assign bus.segm         = segm_q;
    assign bus.frame_done   = boundary;
    assign bus.busy_pending = busy_q;
endmodule
